// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm_if
//  Description : Control bundle between the multi-cycle RV32I main controller
//                and its shared-ALU / shared-memory datapath.
//                master : the controller (drives control, samples status)
//                slave  : the datapath  (drives status, samples control)
//                Status  : opcode[6:0], zero, mem_ready
//                Control : PCWrite, AdrSrc, MemRead, MemWrite, IRWrite,
//                          ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0],
//                          ALUOp[1:0], RegWrite, Branch
//                Debug   : illegal, instret[CNT_W-1:0], state[3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 32
);
    // status from the datapath
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;

    // control to the datapath
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic             RegWrite;
    logic             Branch;

    // trap, statistics and debug
    logic             illegal;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state;

    modport master (
        input  opcode, zero, mem_ready,
        output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, Branch,
               illegal, instret, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, Branch,
               illegal, instret, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Multi-cycle RV32I main controller. Steps every instruction
//                through FETCH / DECODE / EXECUTE / MEM / WB states and drives
//                the control lines of a shared-ALU, shared-memory datapath.
//                Supports a memory wait handshake, JAL, an illegal-opcode trap
//                and a retired-instruction counter.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous, active-high
//                ctrl   - multicycle_control_fsm_if.master (status in,
//                         control / debug out)
//  Parameters  : MEM_WAIT - 1: honour mem_ready in memory states, 0: ignore it
//                TRAP_ILL - 1: park in ILLEGAL on a bad opcode,
//                           0: one-cycle illegal pulse, then FETCH
//                CNT_W    - width of the instret counter
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int MEM_WAIT = 1,
    parameter int TRAP_ILL = 1,
    parameter int CNT_W    = 32
) (
    input  wire                      clk,
    input  wire                      reset,
    multicycle_control_fsm_if.master ctrl
);

    // ------------------------------------------------------------------------
    // Opcodes recognised by the decoder
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_rtype = 7'b0110011;
    localparam logic [6:0] c_op_itype = 7'b0010011;
    localparam logic [6:0] c_op_beq   = 7'b1100011;
    localparam logic [6:0] c_op_jal   = 7'b1101111;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding (codes 12..15 unused; they recover to FETCH)
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    // Per-state control word. fetch and branch are qualifiers that get
    // combined with mem_ready / zero at the output; pc_jump is the
    // unconditional PC load used by JAL.
    typedef struct packed {
        logic       fetch;
        logic       pc_jump;
        logic       memread;
        logic       adrsrc;
        logic       memwrite;
        logic [1:0] resultsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       regwrite;
        logic       branch;
    } ctl_t;

    // ------------------------------------------------------------------------
    // Moore decode of a state into its control word
    // ------------------------------------------------------------------------
    function automatic ctl_t decode_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                // read instruction at PC while the ALU forms PC+4
                c.fetch     = 1'b1;
                c.memread   = 1'b1;
                c.srcb      = 2'b10;
                c.resultsrc = 2'b10;
            end
            S_DECODE: begin
                // OldPC + imm lands in ALUOut as a branch/jump target
                c.srca = 2'b01;
                c.srcb = 2'b01;
            end
            S_MEMADR: begin
                c.srca = 2'b10;
                c.srcb = 2'b01;
            end
            S_MEMREAD: begin
                c.memread = 1'b1;
                c.adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.memwrite = 1'b1;
                c.adrsrc   = 1'b1;
            end
            S_EXEC_R: begin
                c.srca  = 2'b10;
                c.srcb  = 2'b00;
                c.aluop = 2'b10;
            end
            S_EXEC_I: begin
                c.srca  = 2'b10;
                c.srcb  = 2'b01;
                c.aluop = 2'b10;
            end
            S_ALUWB: begin
                c.resultsrc = 2'b00;
                c.regwrite  = 1'b1;
            end
            S_BEQ: begin
                c.srca      = 2'b10;
                c.srcb      = 2'b00;
                c.aluop     = 2'b01;
                c.resultsrc = 2'b00;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                // target already in ALUOut from DECODE; ALU now forms the
                // link value OldPC+4 for the following ALUWB
                c.srca      = 2'b01;
                c.srcb      = 2'b10;
                c.resultsrc = 2'b00;
                c.pc_jump   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    ctl_t             r_ctl;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;

    state_t           w_next;
    logic             w_rdy;
    logic             w_op_known;
    logic             w_ill_decode;
    logic             w_retire;

    // ------------------------------------------------------------------------
    // Memory-ready qualifier
    // ------------------------------------------------------------------------
    generate
        if (MEM_WAIT != 0) begin : g_mem_wait
            assign w_rdy = ctrl.mem_ready;
        end else begin : g_no_mem_wait
            assign w_rdy = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Opcode legality and next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_op_known = 1'b0;
        case (ctrl.opcode)
            c_op_load, c_op_store, c_op_rtype,
            c_op_itype, c_op_beq, c_op_jal: w_op_known = 1'b1;
            default:                        w_op_known = 1'b0;
        endcase
    end

    assign w_ill_decode = (r_state == S_DECODE) && !w_op_known;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctrl.opcode)
                    c_op_load,
                    c_op_store: w_next = S_MEMADR;
                    c_op_rtype: w_next = S_EXEC_R;
                    c_op_itype: w_next = S_EXEC_I;
                    c_op_beq:   w_next = S_BEQ;
                    c_op_jal:   w_next = S_JAL;
                    default:    w_next = (TRAP_ILL != 0) ? S_ILLEGAL : S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (ctrl.opcode == c_op_load) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = w_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_rdy ? S_FETCH : S_MEMWRITE;
            S_EXEC_R:   w_next = S_ALUWB;
            S_EXEC_I:   w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_FETCH;
        endcase
    end

    // An instruction retires on the way back into FETCH, unless it was
    // rejected by the decoder (or we are leaving the trap state).
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) &&
                      (r_state != S_ILLEGAL) && !w_ill_decode;

    // ------------------------------------------------------------------------
    // State, registered control word, trap flag and retire counter.
    // The control word is decoded from the next state so that it is always
    // aligned with r_state, i.e. the outputs are a pure function of the
    // current state without a decode path after the state flops.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_ctl     <= decode_ctl(S_FETCH);
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state   <= w_next;
            r_ctl     <= decode_ctl(w_next);
            // sticky via the self-loop in ILLEGAL; one-shot when not trapping
            r_illegal <= (w_next == S_ILLEGAL) || (w_ill_decode && (TRAP_ILL == 0));
            if (w_retire) begin
                r_instret <= r_instret + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. IRWrite/PCWrite in FETCH follow the memory handshake, and the
    // BEQ PC load follows the live ALU zero flag.
    // ------------------------------------------------------------------------
    assign ctrl.PCWrite   = r_ctl.pc_jump | (r_ctl.fetch & w_rdy) | (r_ctl.branch & ctrl.zero);
    assign ctrl.IRWrite   = r_ctl.fetch & w_rdy;
    assign ctrl.AdrSrc    = r_ctl.adrsrc;
    assign ctrl.MemRead   = r_ctl.memread;
    assign ctrl.MemWrite  = r_ctl.memwrite;
    assign ctrl.ResultSrc = r_ctl.resultsrc;
    assign ctrl.ALUSrcA   = r_ctl.srca;
    assign ctrl.ALUSrcB   = r_ctl.srcb;
    assign ctrl.ALUOp     = r_ctl.aluop;
    assign ctrl.RegWrite  = r_ctl.regwrite;
    assign ctrl.Branch    = r_ctl.branch;
    assign ctrl.illegal   = r_illegal;
    assign ctrl.instret   = r_instret;
    assign ctrl.state     = r_state;

endmodule
`default_nettype wire
